ahb_lite_master: RTL and testbench

AHB-Lite bus initiator that drives the same AHB slave port the top-level wrapper exposes: it turns a simple command interface (address, direction, beat count) into pipelined NONSEQ/SEQ transfers, streams write data from a show-ahead source and returns read data. It handles HREADY wait states and the two-cycle ERROR response. It sits between the system-side control logic and the AHB port, and also serves as the synthesizable stimulus master for top-level verification.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_master_addr_gen.sv | 47 ++++
 rtl/ahb_lite_master.sv | 140 ++++++++++++++
 tb/tb_ahb_lite_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master FSM state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001
   } hburst_t;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [3:0] HPROT_DATA  = 4'b0011;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StBurst,
      StLast,
      StErr
   } mst_state_t;

endpackage

// File: rtl/ahb_master_addr_gen.sv
// Beat counter and word address incrementer for the AHB-Lite master; restarts
// the burst with NONSEQ whenever the next address lands on a 1 KB boundary.
module ahb_master_addr_gen
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [3:0]        load_beats_m1,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output htrans_t           trans,
   output logic              last
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_next;
   logic [3:0]        beats_q;
   htrans_t           trans_q;

   assign addr_next = addr_q + ADDR_W'(4);

   // Address and counter freeze on the final beat so HADDR keeps the last address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         beats_q <= '0;
         trans_q <= NONSEQ;
      end else if (load) begin
         addr_q  <= {load_addr[ADDR_W-1:2], 2'b00};
         beats_q <= load_beats_m1;
         trans_q <= NONSEQ;
      end else if (advance && (beats_q != 4'd0)) begin
         addr_q  <= addr_next;
         beats_q <= beats_q - 4'd1;
         trans_q <= (addr_next[9:0] == 10'd0) ? NONSEQ : SEQ;
      end
   end

   assign addr  = addr_q;
   assign trans = trans_q;
   assign last  = (beats_q == 4'd0);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns address/direction/beat-count commands into pipelined
// NONSEQ/SEQ transfers with wait-state and two-cycle ERROR handling.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_beats_m1,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pop,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              HSELx,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [1:0]        HTRANS,
   output logic [2:0]        HBURST,
   output logic [2:0]        HSIZE,
   output logic [3:0]        HPROT,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   mst_state_t        state_q, state_d;
   logic              write_q;
   hburst_t           burst_q;
   logic [DATA_W-1:0] hwdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              done_q;
   logic              err_q;

   logic              accept;
   logic              addr_phase;
   logic              data_phase;
   logic              addr_done;
   logic              data_done;
   logic              err_first;
   logic              rd_capture;
   logic [ADDR_W-1:0] gen_addr;
   htrans_t           gen_trans;
   logic              gen_last;

   assign accept     = (state_q == StIdle) && cmd_valid;
   assign addr_phase = (state_q == StAddr) || (state_q == StBurst);
   assign data_phase = (state_q == StBurst) || (state_q == StLast);
   assign err_first  = data_phase && (HRESP == HRESP_ERROR) && !HREADY;
   assign addr_done  = addr_phase && HREADY;
   assign data_done  = data_phase && HREADY;
   assign rd_capture = data_done && !write_q && (HRESP == HRESP_OKAY);

   ahb_master_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk           (HCLK),
      .rst_n         (HRESETn),
      .load          (accept),
      .load_addr     (cmd_addr),
      .load_beats_m1 (cmd_beats_m1),
      .advance       (addr_done),
      .addr          (gen_addr),
      .trans         (gen_trans),
      .last          (gen_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) state_d = StAddr;
         end
         StAddr, StBurst: begin
            if (err_first)   state_d = StErr;
            else if (HREADY) state_d = gen_last ? StLast : StBurst;
         end
         StLast: begin
            if (err_first)   state_d = StErr;
            else if (HREADY) state_d = StIdle;
         end
         StErr: begin
            if (HREADY) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         burst_q    <= SINGLE;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_capture;
         done_q     <= ((state_q == StLast) || (state_q == StErr)) && HREADY;
         err_q      <= (state_q == StErr) && HREADY;
         if (rd_capture) rd_data_q <= HRDATA;
         if (wr_pop)     hwdata_q  <= wr_data;
         if (accept) begin
            write_q <= cmd_write;
            burst_q <= (cmd_beats_m1 == 4'd0) ? SINGLE : INCR;
         end
      end
   end

   // The first ERROR cycle must already show IDLE, so the mask is combinational on HRESP.
   assign HTRANS    = (addr_phase && !err_first) ? gen_trans : IDLE;
   assign HADDR     = gen_addr;
   assign HWRITE    = write_q;
   assign HBURST    = burst_q;
   assign HSIZE     = HSIZE_WORD;
   assign HPROT     = HPROT_DATA;
   assign HWDATA    = hwdata_q;
   assign HSELx     = (state_q != StIdle);
   assign wr_pop    = addr_done && write_q;
   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the AHB slave and FIFO,
// records each command's bus activity, and compares against hand-computed values.
module tb_ahb_lite_master;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_beats_m1;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;
   logic        err;
   logic        busy;
   logic        HSELx;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-command observations filled in by run_cmd.
   int          n_addr;
   int          n_rd;
   int          pops;
   int          done_cyc;
   logic        done_err;
   logic        done_ready;
   logic [1:0]  done_trans;
   logic        stall_ok;
   logic [1:0]  err_trans;
   logic [2:0]  obs_burst;
   logic        obs_hwrite;
   logic [31:0] obs_addr  [32];
   logic [1:0]  obs_trans [32];
   logic [31:0] obs_wd    [32];
   logic [31:0] obs_rd    [32];

   ahb_lite_master #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_beats_m1 (cmd_beats_m1),
      .wr_data      (wr_data),
      .wr_pop       (wr_pop),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .HSELx        (HSELx),
      .HADDR        (HADDR),
      .HWRITE       (HWRITE),
      .HTRANS       (HTRANS),
      .HBURST       (HBURST),
      .HSIZE        (HSIZE),
      .HPROT        (HPROT),
      .HWDATA       (HWDATA),
      .HRDATA       (HRDATA),
      .HREADY       (HREADY),
      .HRESP        (HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and act as the slave; cycle 0 is the first address-phase cycle.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] bm1,
                          input logic [31:0] base, input int stall_beat, input int nwait,
                          input int err_beat);
      int          waits;
      int          err_ph;
      logic        dp_v;
      int          dp_b;
      int          cur;
      logic        rdy;
      logic        p_stall;
      logic [31:0] p_addr;
      logic [31:0] p_wd;
      logic [1:0]  p_trans;
      n_addr = 0; n_rd = 0; pops = 0; done_cyc = -1; done_err = 1'b0; done_ready = 1'b0;
      done_trans = 2'b11; stall_ok = 1'b1; err_trans = 2'b11;
      waits = 0; err_ph = 0; dp_v = 1'b0; dp_b = 0; p_stall = 1'b0;
      p_addr = '0; p_wd = '0; p_trans = '0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_beats_m1 = bm1;
      wr_data = base; HREADY = 1'b1; HRESP = 2'b00;
      #1;
      check("cmd_ready_accept", {31'd0, cmd_ready}, 32'd1);
      @(posedge HCLK); #2;
      cmd_valid = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         rdy    = 1'b1;
         HRESP  = 2'b00;
         HRDATA = base + 32'(dp_b);
         if (dp_v && dp_b == stall_beat && waits < nwait) begin
            rdy = 1'b0;
            waits++;
         end else if (dp_v && dp_b == err_beat) begin
            HRESP = 2'b01;
            rdy   = (err_ph == 1);
            err_ph++;
         end
         HREADY  = rdy;
         wr_data = base + 32'(pops);
         #1;
         if (cyc == 0) begin
            check("done_single_pulse", {31'd0, done}, 32'd0);
            obs_burst  = HBURST;
            obs_hwrite = HWRITE;
         end
         if (err_ph == 1 && !rdy) err_trans = HTRANS;
         if (p_stall && (HADDR != p_addr || HTRANS != p_trans || HWDATA != p_wd)) stall_ok = 1'b0;
         p_stall = !rdy; p_addr = HADDR; p_trans = HTRANS; p_wd = HWDATA;
         if (wr_pop) pops++;
         if (rd_valid && n_rd < 32) begin
            obs_rd[n_rd] = rd_data;
            n_rd++;
         end
         if (done) begin
            done_cyc = cyc; done_err = err; done_ready = cmd_ready; done_trans = HTRANS;
            break;
         end
         cur = -1;
         if (rdy && dp_v && wr && dp_b >= 0 && dp_b < 32) obs_wd[dp_b] = HWDATA;
         if (rdy && HTRANS[1] && n_addr < 32) begin
            cur = n_addr;
            obs_addr[n_addr]  = HADDR;
            obs_trans[n_addr] = HTRANS;
            n_addr++;
         end
         if (rdy) begin
            dp_v = (cur >= 0);
            dp_b = cur;
         end
         @(posedge HCLK); #2;
      end
      if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic seen;
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats_m1 = '0;
      wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK); HRESETn = 1'b1;
      @(posedge HCLK); #3;

      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_hsel",      {31'd0, HSELx},     32'd0);
      check("rst_htrans",    {30'd0, HTRANS},    32'd0);
      check("rst_hburst",    {29'd0, HBURST},    32'd0);
      check("rst_hsize",     {29'd0, HSIZE},     32'd2);
      check("rst_hprot",     {28'd0, HPROT},     32'd3);
      check("rst_haddr",     HADDR,              32'd0);
      check("rst_hwdata",    HWDATA,             32'd0);
      check("rst_outs",      {27'd0, done, err, rd_valid, wr_pop, HWRITE}, 32'd0);

      // Single write; cmd_addr low bits must be ignored.
      run_cmd(1'b1, 32'h0000_0013, 4'd0, 32'hDEAD_BEEF, -1, 0, -1);
      check("sw_n_addr",  32'(n_addr),          32'd1);
      check("sw_haddr",   obs_addr[0],          32'h10);
      check("sw_htrans",  {30'd0, obs_trans[0]}, 32'd2);
      check("sw_hburst",  {29'd0, obs_burst},   32'd0);
      check("sw_hwrite",  {31'd0, obs_hwrite},  32'd1);
      check("sw_hwdata",  obs_wd[0],            32'hDEAD_BEEF);
      check("sw_pops",    32'(pops),            32'd1);
      check("sw_done",    32'(done_cyc),        32'd2);
      check("sw_err",     {31'd0, done_err},    32'd0);
      check("sw_ready",   {31'd0, done_ready},  32'd1);

      // 4-beat read, accepted back-to-back in the previous done cycle.
      run_cmd(1'b0, 32'h0000_0100, 4'd3, 32'h0000_00A0, -1, 0, -1);
      check("rd4_n_addr", 32'(n_addr), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("rd4_haddr",  obs_addr[i], 32'h100 + 32'(4 * i));
         check("rd4_htrans", {30'd0, obs_trans[i]}, (i == 0) ? 32'd2 : 32'd3);
         check("rd4_data",   obs_rd[i], 32'hA0 + 32'(i));
      end
      check("rd4_n_rd",   32'(n_rd),              32'd4);
      check("rd4_hburst", {29'd0, obs_burst},     32'd1);
      check("rd4_hwrite", {31'd0, obs_hwrite},    32'd0);
      check("rd4_pops",   32'(pops),              32'd0);
      check("rd4_done",   32'(done_cyc),          32'd5);
      check("rd4_idle",   {30'd0, done_trans},    32'd0);

      // 4-beat write, two wait states on the second beat's data phase.
      run_cmd(1'b1, 32'h0000_0200, 4'd3, 32'h1000_0000, 1, 2, -1);
      check("stall_stable", {31'd0, stall_ok}, 32'd1);
      check("stall_pops",   32'(pops),         32'd4);
      check("stall_done",   32'(done_cyc),     32'd7);
      check("stall_haddr2", obs_addr[2],       32'h208);
      for (int i = 0; i < 4; i++) check("stall_hwdata", obs_wd[i], 32'h1000_0000 + 32'(i));

      // 4-beat write across the 1 KB boundary.
      run_cmd(1'b1, 32'h0000_03F8, 4'd3, 32'h2000_0000, -1, 0, -1);
      check("kb_n_addr", 32'(n_addr), 32'd4);
      check("kb_haddr2", obs_addr[2], 32'h400);
      check("kb_htrans", {24'd0, obs_trans[0], obs_trans[1], obs_trans[2], obs_trans[3]},
            32'b10_11_10_11);
      check("kb_pops",   32'(pops),     32'd4);
      check("kb_hwdata3", obs_wd[3],    32'h2000_0003);
      check("kb_done",   32'(done_cyc), 32'd5);

      // 8-beat read, ERROR on the third beat's data phase.
      run_cmd(1'b0, 32'h0000_0040, 4'd7, 32'h0000_00B0, -1, 0, 2);
      check("er_trans_idle", {30'd0, err_trans}, 32'd0);
      check("er_n_addr",     32'(n_addr),        32'd3);
      check("er_n_rd",       32'(n_rd),          32'd2);
      check("er_rd0",        obs_rd[0],          32'hB0);
      check("er_rd1",        obs_rd[1],          32'hB1);
      check("er_done",       32'(done_cyc),      32'd5);
      check("er_err",        {31'd0, done_err},  32'd1);
      check("er_ready",      {31'd0, done_ready}, 32'd1);

      // 16-beat write, reset asserted during the second beat's address phase.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h800; cmd_beats_m1 = 4'd15;
      wr_data = 32'h3000_0000; HREADY = 1'b1; HRESP = 2'b00;
      @(posedge HCLK); #2;
      cmd_valid = 1'b0;
      @(posedge HCLK); #2;
      check("rs_pre_seq", {30'd0, HTRANS}, 32'd3);
      HRESETn = 1'b0;
      #1;
      check("rs_ready",  {31'd0, cmd_ready}, 32'd1);
      check("rs_htrans", {30'd0, HTRANS},    32'd0);
      check("rs_haddr",  HADDR,              32'd0);
      check("rs_hwdata", HWDATA,             32'd0);
      check("rs_outs",   {25'd0, busy, HSELx, done, err, rd_valid, wr_pop, HWRITE}, 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge HCLK); #2;
         if (done || wr_pop) seen = 1'b1;
      end
      check("rs_quiet", {31'd0, seen}, 32'd0);
      @(negedge HCLK); HRESETn = 1'b1;
      @(posedge HCLK); #2;
      run_cmd(1'b0, 32'h0000_0044, 4'd0, 32'h0000_0055, -1, 0, -1);
      check("rs_after_rd",   obs_rd[0],     32'h55);
      check("rs_after_n_rd", 32'(n_rd),     32'd1);
      check("rs_after_done", 32'(done_cyc), 32'd2);
      check("rs_after_addr", obs_addr[0],   32'h44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
